// File: rtl/sun_tracker_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : sun_tracker_ctrl
//  Purpose  : Two-axis sun-tracker sequencer. Latches one four-quadrant LDR
//             sample, compares opposing sensor sums and drives the azimuth
//             and elevation servo_driver BTN inputs one axis at a time:
//             EVAL_AZ -> MOVE_AZ -> SETTLE_AZ -> EVAL_EL -> MOVE_EL ->
//             SETTLE_EL -> WAIT.
//  Optional : SUN_TRACKER_MANUAL_EN adds a manual jog mode (man_* inputs).
//  Ports    :
//    clk, rst_n           clock / asynchronous active-low reset
//    enable               tracking enable (low forces WAIT on next edge)
//    sample_valid         one-cycle strobe qualifying ldr_* (WAIT only)
//    ldr_tl/tr/bl/br      12-bit light-sensor readings
//    az_lim_cw/ccw        azimuth end-stops, active-high
//    el_lim_cw/ccw        elevation end-stops, active-high
//    az_cw/az_ccw         azimuth servo_driver BTN_0/BTN_1
//    el_cw/el_ccw         elevation servo_driver BTN_0/BTN_1
//    busy                 high whenever state != WAIT
//    cycle_done           one-cycle pulse at end of a tracking cycle
//    state                current state code (WAIT=0 .. SETTLE_EL=6)
//    man_mode, man_*      (SUN_TRACKER_MANUAL_EN only) manual jog inputs
//  Revision : 1.0  initial release
// ============================================================================
module sun_tracker_ctrl #(
    parameter int unsigned THRESH       = 64,
    parameter int unsigned MOVE_TICKS   = 50000000,
    parameter int unsigned SETTLE_TICKS = 20000000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [11:0] ldr_tl,
    input  logic [11:0] ldr_tr,
    input  logic [11:0] ldr_bl,
    input  logic [11:0] ldr_br,
    input  logic        az_lim_cw,
    input  logic        az_lim_ccw,
    input  logic        el_lim_cw,
    input  logic        el_lim_ccw,
`ifdef SUN_TRACKER_MANUAL_EN
    input  logic        man_mode,
    input  logic        man_az_cw,
    input  logic        man_az_ccw,
    input  logic        man_el_cw,
    input  logic        man_el_ccw,
`endif
    output logic        az_cw,
    output logic        az_ccw,
    output logic        el_cw,
    output logic        el_ccw,
    output logic        busy,
    output logic        cycle_done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_EVAL_AZ   = 3'd1,
        ST_MOVE_AZ   = 3'd2,
        ST_SETTLE_AZ = 3'd3,
        ST_EVAL_EL   = 3'd4,
        ST_MOVE_EL   = 3'd5,
        ST_SETTLE_EL = 3'd6
    } state_t;

    localparam logic [13:0]      c_thresh      = 14'(THRESH);
    localparam logic [CNT_W-1:0] c_move_last   = CNT_W'(MOVE_TICKS - 1);
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_TICKS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [11:0]        r_tl, r_tr, r_bl, r_br;
    logic               r_dir;          // 0 = CW, 1 = CCW for the axis in motion
    logic               w_dir_nxt;
    logic               w_latch;
    logic               w_done_nxt;
    logic               r_az_cw, r_az_ccw, r_el_cw, r_el_ccw;
    logic               w_az_cw_nxt, w_az_ccw_nxt, w_el_cw_nxt, w_el_ccw_nxt;
    logic               r_busy, r_done;

    // Opposing sums are 13 bits; the extra MSB on the compare side leaves
    // room for adding the deadband without wrap-around.
    logic [12:0] w_sum_l, w_sum_r, w_sum_t, w_sum_b;
    logic [13:0] w_l, w_r, w_t, w_b;
    logic        w_az_go_cw, w_az_go_ccw, w_el_go_cw, w_el_go_ccw;
    logic        w_az_lim_sel, w_el_lim_sel;

    assign w_sum_l = {1'b0, r_tl} + {1'b0, r_bl};
    assign w_sum_r = {1'b0, r_tr} + {1'b0, r_br};
    assign w_sum_t = {1'b0, r_tl} + {1'b0, r_tr};
    assign w_sum_b = {1'b0, r_bl} + {1'b0, r_br};
    assign w_l     = {1'b0, w_sum_l};
    assign w_r     = {1'b0, w_sum_r};
    assign w_t     = {1'b0, w_sum_t};
    assign w_b     = {1'b0, w_sum_b};

    assign w_az_go_cw  = w_r > (w_l + c_thresh);
    assign w_az_go_ccw = w_l > (w_r + c_thresh);
    assign w_el_go_cw  = w_t > (w_b + c_thresh);
    assign w_el_go_ccw = w_b > (w_t + c_thresh);

    // End-stop belonging to the direction currently being driven.
    assign w_az_lim_sel = r_dir ? az_lim_ccw : az_lim_cw;
    assign w_el_lim_sel = r_dir ? el_lim_ccw : el_lim_cw;

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_latch     = 1'b0;
        w_done_nxt  = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_WAIT;
        end else begin
            case (r_state)
                ST_WAIT: begin
                    if (sample_valid) begin
                        w_latch     = 1'b1;
                        w_state_nxt = ST_EVAL_AZ;
                    end
                end
                ST_EVAL_AZ: begin
                    if (w_az_go_cw && !az_lim_cw) begin
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = ST_MOVE_AZ;
                    end else if (w_az_go_ccw && !az_lim_ccw) begin
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = ST_MOVE_AZ;
                    end else begin
                        w_state_nxt = ST_EVAL_EL;
                    end
                end
                ST_MOVE_AZ: begin
                    if (w_az_lim_sel || (r_cnt == c_move_last))
                        w_state_nxt = ST_SETTLE_AZ;
                end
                ST_SETTLE_AZ: begin
                    if (r_cnt == c_settle_last)
                        w_state_nxt = ST_EVAL_EL;
                end
                ST_EVAL_EL: begin
                    if (w_el_go_cw && !el_lim_cw) begin
                        w_dir_nxt   = 1'b0;
                        w_state_nxt = ST_MOVE_EL;
                    end else if (w_el_go_ccw && !el_lim_ccw) begin
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = ST_MOVE_EL;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_done_nxt  = 1'b1;
                    end
                end
                ST_MOVE_EL: begin
                    if (w_el_lim_sel || (r_cnt == c_move_last))
                        w_state_nxt = ST_SETTLE_EL;
                end
                ST_SETTLE_EL: begin
                    if (r_cnt == c_settle_last) begin
                        w_state_nxt = ST_WAIT;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_WAIT;
            endcase
        end

`ifdef SUN_TRACKER_MANUAL_EN
        // Manual mode parks the sequencer in WAIT with no sample capture.
        if (man_mode) begin
            w_state_nxt = ST_WAIT;
            w_dir_nxt   = r_dir;
            w_latch     = 1'b0;
            w_done_nxt  = 1'b0;
        end
`endif

        // Motion outputs are decoded from the state being entered so they
        // rise together with MOVE_* and fall together with its exit.
        w_az_cw_nxt  = (w_state_nxt == ST_MOVE_AZ) && !w_dir_nxt;
        w_az_ccw_nxt = (w_state_nxt == ST_MOVE_AZ) &&  w_dir_nxt;
        w_el_cw_nxt  = (w_state_nxt == ST_MOVE_EL) && !w_dir_nxt;
        w_el_ccw_nxt = (w_state_nxt == ST_MOVE_EL) &&  w_dir_nxt;

`ifdef SUN_TRACKER_MANUAL_EN
        if (man_mode) begin
            w_az_cw_nxt  = man_az_cw  && !man_az_ccw && !az_lim_cw;
            w_az_ccw_nxt = man_az_ccw && !man_az_cw  && !az_lim_ccw;
            // Azimuth wins: elevation is blocked while either AZ line is set.
            w_el_cw_nxt  = man_el_cw  && !man_el_ccw && !el_lim_cw
                           && !(w_az_cw_nxt || w_az_ccw_nxt);
            w_el_ccw_nxt = man_el_ccw && !man_el_cw  && !el_lim_ccw
                           && !(w_az_cw_nxt || w_az_ccw_nxt);
        end
`endif
    end

    // ------------------------------------------------------------------
    // State, counter, sample and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_WAIT;
            r_cnt    <= '0;
            r_dir    <= 1'b0;
            r_tl     <= '0;
            r_tr     <= '0;
            r_bl     <= '0;
            r_br     <= '0;
            r_az_cw  <= 1'b0;
            r_az_ccw <= 1'b0;
            r_el_cw  <= 1'b0;
            r_el_ccw <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;

            // Shared tick counter restarts on every state change, so each
            // MOVE/SETTLE phase sees it begin at zero.
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if ((r_state == ST_MOVE_AZ) || (r_state == ST_SETTLE_AZ) ||
                     (r_state == ST_MOVE_EL) || (r_state == ST_SETTLE_EL))
                r_cnt <= r_cnt + 1'b1;

            if (w_latch) begin
                r_tl <= ldr_tl;
                r_tr <= ldr_tr;
                r_bl <= ldr_bl;
                r_br <= ldr_br;
            end

            r_az_cw  <= w_az_cw_nxt;
            r_az_ccw <= w_az_ccw_nxt;
            r_el_cw  <= w_el_cw_nxt;
            r_el_ccw <= w_el_ccw_nxt;
            r_busy   <= (w_state_nxt != ST_WAIT);
            r_done   <= w_done_nxt;
        end
    end

    assign az_cw      = r_az_cw;
    assign az_ccw     = r_az_ccw;
    assign el_cw      = r_el_cw;
    assign el_ccw     = r_el_ccw;
    assign busy       = r_busy;
    assign cycle_done = r_done;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sun_tracker_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_sun_tracker_ctrl
//  Purpose  : Scoreboard bench for sun_tracker_ctrl. Each scenario pushes its
//             expected per-cycle output trace; a monitor pops and compares
//             one entry on every falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sun_tracker_ctrl;

    localparam int unsigned c_move   = 8;
    localparam int unsigned c_settle = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_valid;
    logic [11:0] ldr_tl, ldr_tr, ldr_bl, ldr_br;
    logic        az_lim_cw, az_lim_ccw, el_lim_cw, el_lim_ccw;
    logic        az_cw, az_ccw, el_cw, el_ccw, busy, cycle_done;
    logic [2:0]  state;
`ifdef SUN_TRACKER_MANUAL_EN
    logic        man_mode   = 1'b0;
    logic        man_az_cw  = 1'b0;
    logic        man_az_ccw = 1'b0;
    logic        man_el_cw  = 1'b0;
    logic        man_el_ccw = 1'b0;
`endif

    always #5 clk = ~clk;

    sun_tracker_ctrl #(
        .THRESH       (64),
        .MOVE_TICKS   (c_move),
        .SETTLE_TICKS (c_settle),
        .CNT_W        (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .ldr_tl       (ldr_tl),
        .ldr_tr       (ldr_tr),
        .ldr_bl       (ldr_bl),
        .ldr_br       (ldr_br),
        .az_lim_cw    (az_lim_cw),
        .az_lim_ccw   (az_lim_ccw),
        .el_lim_cw    (el_lim_cw),
        .el_lim_ccw   (el_lim_ccw),
`ifdef SUN_TRACKER_MANUAL_EN
        .man_mode     (man_mode),
        .man_az_cw    (man_az_cw),
        .man_az_ccw   (man_az_ccw),
        .man_el_cw    (man_el_cw),
        .man_el_ccw   (man_el_ccw),
`endif
        .az_cw        (az_cw),
        .az_ccw       (az_ccw),
        .el_cw        (el_cw),
        .el_ccw       (el_ccw),
        .busy         (busy),
        .cycle_done   (cycle_done),
        .state        (state)
    );

    // Output vector layout: {state[2:0], busy, cycle_done, az_cw, az_ccw, el_cw, el_ccw}
    typedef struct {
        logic [8:0] vec;
        int         scen;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_scen = 0;

    function automatic logic [8:0] v(input logic [2:0] st, input logic bsy,
                                     input logic dn, input logic [3:0] m);
        return {st, bsy, dn, m};
    endfunction

    function automatic logic [8:0] act_vec();
        return {state, busy, cycle_done, az_cw, az_ccw, el_cw, el_ccw};
    endfunction

    // Expected trace entries
    logic [8:0] e_w, e_done, e_eaz, e_eel, e_saz, e_sel;
    logic [8:0] e_maz_cw, e_maz_ccw, e_mel_cw, e_mel_ccw;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [8:0] x, input int n);
        exp_t e;
        e.vec  = x;
        e.scen = cur_scen;
        repeat (n) sb.push_back(e);
    endtask

    // One-cycle sample strobe; called at posedge+2, returns at posedge+2.
    task automatic strobe(input logic [11:0] tl, input logic [11:0] tr,
                          input logic [11:0] bl, input logic [11:0] br);
        ldr_tl = tl; ldr_tr = tr; ldr_bl = bl; ldr_br = br;
        sample_valid = 1'b1;
        @(posedge clk); #2;
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        @(posedge clk);
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_s%0d: %0d entries left, required 0", cur_scen, sb.size());
            sb.delete();
        end
        #2;
    endtask

    // Monitor: one trace compare per falling edge, plus axis invariants.
    always @(negedge clk) begin
        logic [8:0] a;
        a = act_vec();
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("trace_s%0d", e.scen), a, e.vec);
        end
        check("invariant", {6'b0, az_cw & az_ccw, el_cw & el_ccw,
                            (az_cw | az_ccw) & (el_cw | el_ccw)}, 9'b0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        e_w       = v(3'd0, 1'b0, 1'b0, 4'b0000);
        e_done    = v(3'd0, 1'b0, 1'b1, 4'b0000);
        e_eaz     = v(3'd1, 1'b1, 1'b0, 4'b0000);
        e_maz_cw  = v(3'd2, 1'b1, 1'b0, 4'b1000);
        e_maz_ccw = v(3'd2, 1'b1, 1'b0, 4'b0100);
        e_saz     = v(3'd3, 1'b1, 1'b0, 4'b0000);
        e_eel     = v(3'd4, 1'b1, 1'b0, 4'b0000);
        e_mel_cw  = v(3'd5, 1'b1, 1'b0, 4'b0010);
        e_mel_ccw = v(3'd5, 1'b1, 1'b0, 4'b0001);
        e_sel     = v(3'd6, 1'b1, 1'b0, 4'b0000);

        rst_n = 1'b0; enable = 1'b1; sample_valid = 1'b0;
        ldr_tl = '0; ldr_tr = '0; ldr_bl = '0; ldr_br = '0;
        az_lim_cw = 1'b0; az_lim_ccw = 1'b0; el_lim_cw = 1'b0; el_lim_ccw = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("reset_state", act_vec(), e_w);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // 1: asynchronous reset during the first MOVE_AZ cycle
        cur_scen = 1;
        push(e_w, 1); push(e_eaz, 1); push(e_maz_cw, 1); push(e_w, 3);
        strobe(12'd100, 12'd400, 12'd100, 12'd400);
        @(posedge clk); #7;
        rst_n = 1'b0;
        #1;
        check("reset_async", act_vec(), e_w);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        wait_drain();

        // 2: R > L, T == B -> AZ_CW only
        cur_scen = 2;
        push(e_w, 1); push(e_eaz, 1); push(e_maz_cw, c_move); push(e_saz, c_settle);
        push(e_eel, 1); push(e_done, 1); push(e_w, 1);
        strobe(12'd100, 12'd400, 12'd100, 12'd400);
        wait_drain();

        // 3: L == R, T > B -> elevation CW only
        cur_scen = 3;
        push(e_w, 1); push(e_eaz, 1); push(e_eel, 1); push(e_mel_cw, c_move);
        push(e_sel, c_settle); push(e_done, 1); push(e_w, 1);
        strobe(12'd500, 12'd500, 12'd100, 12'd100);
        wait_drain();

        // 4a: differences exactly at the deadband -> no motion on either axis
        cur_scen = 4;
        push(e_w, 1); push(e_eaz, 1); push(e_eel, 1); push(e_done, 1); push(e_w, 1);
        strobe(12'd100, 12'd100, 12'd164, 12'd100);
        wait_drain();

        // 4b: differences one past the deadband -> AZ_CCW then EL_CCW
        cur_scen = 5;
        push(e_w, 1); push(e_eaz, 1); push(e_maz_ccw, c_move); push(e_saz, c_settle);
        push(e_eel, 1); push(e_mel_ccw, c_move); push(e_sel, c_settle);
        push(e_done, 1); push(e_w, 1);
        strobe(12'd100, 12'd100, 12'd165, 12'd100);
        wait_drain();

        // 5: AZ_LIM_CW rises in the 3rd move cycle; elevation still runs
        cur_scen = 6;
        push(e_w, 1); push(e_eaz, 1); push(e_maz_cw, 3); push(e_saz, c_settle);
        push(e_eel, 1); push(e_mel_cw, c_move); push(e_sel, c_settle);
        push(e_done, 1); push(e_w, 1);
        strobe(12'd100, 12'd400, 12'd50, 12'd300);
        repeat (3) @(posedge clk);
        #2;
        az_lim_cw = 1'b1;
        wait_drain();

        // 5b: limit already high at EVAL_AZ -> straight to EVAL_EL, no settle
        cur_scen = 7;
        push(e_w, 1); push(e_eaz, 1); push(e_eel, 1); push(e_mel_cw, c_move);
        push(e_sel, c_settle); push(e_done, 1); push(e_w, 1);
        strobe(12'd100, 12'd400, 12'd50, 12'd300);
        wait_drain();
        az_lim_cw = 1'b0;

        // 6a: strobe during MOVE_AZ must not replace the latched sample
        cur_scen = 8;
        push(e_w, 1); push(e_eaz, 1); push(e_maz_cw, c_move); push(e_saz, c_settle);
        push(e_eel, 1); push(e_done, 1); push(e_w, 1);
        strobe(12'd100, 12'd400, 12'd100, 12'd400);
        @(posedge clk); #2;
        strobe(12'd500, 12'd500, 12'd100, 12'd100);
        wait_drain();

        // 6b: ENABLE dropped in the 2nd MOVE_EL cycle -> WAIT, no CYCLE_DONE
        cur_scen = 9;
        push(e_w, 1); push(e_eaz, 1); push(e_eel, 1); push(e_mel_cw, 2); push(e_w, 4);
        strobe(12'd500, 12'd500, 12'd100, 12'd100);
        repeat (3) @(posedge clk);
        #2;
        enable = 1'b0;
        wait_drain();
        enable = 1'b1;

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
